tt_um_i2c_to_apb: RTL and testbench

//  I2C target (slave) bridging onto an internal APB3 bus that carries a 16x8 register file.

---
 rtl/i2c_apb_pkg.sv | 26 ++
 rtl/i2c_apb_if.sv | 24 ++
 rtl/apb_regfile.sv | 29 ++
 rtl/tt_um_i2c_to_apb.sv | 245 ++++++++++++++++++++++++
 tb/tb_tt_um_i2c_to_apb.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/i2c_apb_pkg.sv
// Shared types and defaults for the I2C-to-APB bridge.
package i2c_apb_pkg;

    localparam logic [6:0]  I2C_ADDR_DEF = 7'h2A;
    localparam int unsigned NREGS_DEF    = 16;
    localparam int unsigned APB_AW       = $clog2(NREGS_DEF);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_state_e;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

endpackage

// File: rtl/i2c_apb_if.sv
// Internal APB3 bus between the I2C front end (master) and the register file (slave).
interface i2c_apb_if #(
    parameter int unsigned AW = 4
) ();

    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [7:0]    pwdata;
    logic [7:0]    prdata;
    logic          pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );

endinterface

// File: rtl/apb_regfile.sv
// APB3 slave holding NREGS 8-bit registers; register 0 is exported directly.
module apb_regfile
    import i2c_apb_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    i2c_apb_if.slave    apb,
    output logic [7:0]  reg0_o
);

    logic [7:0] regs_q [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (apb.psel && apb.penable && apb.pwrite) begin
            regs_q[apb.paddr] <= apb.pwdata;
        end
    end

    assign apb.prdata = regs_q[apb.paddr];
    assign apb.pready = 1'b1;
    assign reg0_o     = regs_q[0];

endmodule

// File: rtl/tt_um_i2c_to_apb.sv
// TinyTapeout top: I2C target with synchronisers, protocol FSM and APB master
// sequencing in front of a small APB register file.
module tt_um_i2c_to_apb
    import i2c_apb_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR = I2C_ADDR_DEF,
    parameter int unsigned NREGS    = NREGS_DEF
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int unsigned AW = $clog2(NREGS);

    // rst_n is active-high despite its name.
    logic rst;
    assign rst = rst_n;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, ui_in, uio_in[7:3], uio_in[0]};

    // [0],[1] synchroniser, [2] history; reset to the idle-high bus level.
    logic [2:0] scl_q, sda_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], uio_in[2]};
            sda_q <= {sda_q[1:0], uio_in[1]};
        end
    end

    logic scl_s, scl_h, sda_s, sda_h;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_s     = scl_q[1];
    assign scl_h     = scl_q[2];
    assign sda_s     = sda_q[1];
    assign sda_h     = sda_q[2];
    assign scl_rise  = scl_s & ~scl_h;
    assign scl_fall  = ~scl_s & scl_h;
    assign start_det = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

    i2c_apb_if #(.AW(AW)) apb_bus ();

    logic [7:0] reg0;

    apb_regfile #(.NREGS(NREGS)) u_regs (
        .clk    (clk),
        .rst    (rst),
        .apb    (apb_bus.slave),
        .reg0_o (reg0)
    );

    i2c_state_e    state_q, state_d;
    apb_state_e    apb_st_q, apb_st_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          sda_oe_q, sda_oe_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [7:0]    pwdata_q, pwdata_d;
    logic          pwrite_q, pwrite_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            apb_st_q <= APB_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            ptr_q    <= '0;
            rw_q     <= 1'b0;
            sda_oe_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            apb_st_q <= apb_st_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            rw_q     <= rw_d;
            sda_oe_q <= sda_oe_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
        end
    end

    logic          rx_state, byte_end, rd_done, apb_go, apb_wr;
    logic [AW-1:0] ptr_inc;

    assign rx_state = (state_q == ST_ADDR) || (state_q == ST_REG) || (state_q == ST_WDATA);
    assign byte_end = rx_state && scl_fall && (bitcnt_q == 4'd8);
    assign rd_done  = (apb_st_q == APB_ACCESS) && !pwrite_q && apb_bus.pready;
    assign ptr_inc  = (ptr_q == AW'(NREGS - 1)) ? '0 : ptr_q + AW'(1);

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        rw_d     = rw_q;
        sda_oe_d = sda_oe_q;
        apb_go   = 1'b0;
        apb_wr   = 1'b0;

        if (rx_state && scl_rise) begin
            shift_d  = {shift_q[6:0], sda_s};
            bitcnt_d = bitcnt_q + 4'd1;
        end

        unique case (state_q)
            ST_ADDR: begin
                if (byte_end) begin
                    if (shift_q[7:1] == I2C_ADDR) begin
                        sda_oe_d = 1'b1;
                        rw_d     = shift_q[0];
                        state_d  = ST_ADDR_ACK;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    bitcnt_d = '0;
                    if (rw_q) begin
                        apb_go  = 1'b1;
                        state_d = ST_RDATA;
                    end else begin
                        state_d = ST_REG;
                    end
                end
            end
            ST_REG: begin
                if (byte_end) begin
                    ptr_d    = AW'(32'(shift_q) % NREGS);
                    sda_oe_d = 1'b1;
                    state_d  = ST_REG_ACK;
                end
            end
            ST_WDATA: begin
                if (byte_end) begin
                    sda_oe_d = 1'b1;
                    apb_go   = 1'b1;
                    apb_wr   = 1'b1;
                    ptr_d    = ptr_inc;
                    state_d  = ST_WDATA_ACK;
                end
            end
            ST_REG_ACK, ST_WDATA_ACK: begin
                if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    bitcnt_d = '0;
                    state_d  = ST_WDATA;
                end
            end
            ST_RDATA: begin
                // First bit is driven once the read lands, not at the SCL edge.
                if (rd_done) begin
                    shift_d  = apb_bus.prdata;
                    sda_oe_d = ~apb_bus.prdata[7];
                    bitcnt_d = '0;
                    ptr_d    = ptr_inc;
                end else if (scl_rise) begin
                    bitcnt_d = bitcnt_q + 4'd1;
                end else if (scl_fall) begin
                    if (bitcnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_RDATA_ACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b1};
                        sda_oe_d = ~shift_q[6];
                    end
                end
            end
            ST_RDATA_ACK: begin
                if (scl_rise && sda_s) begin
                    state_d = ST_IDLE;
                end else if (scl_fall) begin
                    bitcnt_d = '0;
                    apb_go   = 1'b1;
                    state_d  = ST_RDATA;
                end
            end
            default: ;
        endcase

        if (start_det) begin
            state_d  = ST_ADDR;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
        end
    end

    // APB sequencing runs independently so a started transfer always completes.
    always_comb begin
        apb_st_d = apb_st_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;

        unique case (apb_st_q)
            APB_IDLE: begin
                if (apb_go) begin
                    apb_st_d = APB_SETUP;
                    paddr_d  = ptr_q;
                    pwdata_d = shift_q;
                    pwrite_d = apb_wr;
                end
            end
            APB_SETUP:  apb_st_d = APB_ACCESS;
            APB_ACCESS: if (apb_bus.pready) apb_st_d = APB_IDLE;
            default:    apb_st_d = APB_IDLE;
        endcase
    end

    assign apb_bus.psel    = (apb_st_q != APB_IDLE);
    assign apb_bus.penable = (apb_st_q == APB_ACCESS);
    assign apb_bus.pwrite  = pwrite_q;
    assign apb_bus.paddr   = paddr_q;
    assign apb_bus.pwdata  = pwdata_q;

    assign uo_out  = reg0;
    assign uio_out = '0;
    assign uio_oe  = {6'b0, sda_oe_q, 1'b0};

endmodule

// File: tb/tb_tt_um_i2c_to_apb.sv
// Directed bench: a bit-banged I2C controller exercising writes, bursts, reads,
// wrong address, aborted bytes and mid-transfer reset.
module tb_tt_um_i2c_to_apb;

    localparam int Q = 250;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena   = 1'b1;
    logic [7:0] ui_in = 8'h3C;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic [7:0] uio_in, uo_out, uio_out, uio_oe;

    assign sda_line = sda_m & ~uio_oe[1];
    assign uio_in   = {5'b0, scl_m, sda_line, 1'b0};

    tt_um_i2c_to_apb dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int oe_cnt = 0;

    always @(posedge clk) if (uio_oe[1]) oe_cnt <= oe_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        send_bit(~mack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         oe_snap;

        #100 rst_n = 1'b0;
        #100;
        check("reset uo_out", uo_out, 8'h00);
        check("reset uio_oe", uio_oe, 8'h00);
        check("reset uio_out", uio_out, 8'h00);

        // Single write to register 0
        i2c_start();
        write_byte(8'h54, ack); check("wr addr ack", ack, 1'b1);
        write_byte(8'h00, ack); check("wr ptr ack", ack, 1'b1);
        write_byte(8'hA5, ack); check("wr data ack", ack, 1'b1);
        i2c_stop();
        check("wr uo_out", uo_out, 8'hA5);

        // Burst wrapping from register 15 to 0
        i2c_start();
        write_byte(8'h54, ack); check("burst addr ack", ack, 1'b1);
        write_byte(8'h0F, ack); check("burst ptr ack", ack, 1'b1);
        write_byte(8'h11, ack); check("burst d0 ack", ack, 1'b1);
        write_byte(8'h22, ack); check("burst d1 ack", ack, 1'b1);
        i2c_stop();
        check("burst uo_out", uo_out, 8'h22);

        i2c_start();
        write_byte(8'h54, ack); check("rdw addr ack", ack, 1'b1);
        write_byte(8'h0F, ack); check("rdw ptr ack", ack, 1'b1);
        i2c_start();
        write_byte(8'h55, ack); check("rdw raddr ack", ack, 1'b1);
        read_byte(d, 1'b1); check("rd reg15", d, 8'h11);
        read_byte(d, 1'b0); check("rd wrap reg0", d, 8'h22);
        check("rdw released", uio_oe, 8'h00);
        i2c_stop();

        // Single read with NACK
        i2c_start();
        write_byte(8'h54, ack); check("rd1 addr ack", ack, 1'b1);
        write_byte(8'h00, ack); check("rd1 ptr ack", ack, 1'b1);
        i2c_start();
        write_byte(8'h55, ack); check("rd1 raddr ack", ack, 1'b1);
        read_byte(d, 1'b0); check("rd1 reg0", d, 8'h22);
        check("rd1 released", uio_oe, 8'h00);
        i2c_stop();

        // Wrong address must never drive SDA
        oe_snap = oe_cnt;
        i2c_start();
        write_byte(8'h60, ack); check("bad addr nack", ack, 1'b0);
        i2c_stop();
        check("bad addr no drive", oe_cnt, oe_snap);
        check("bad addr regs", uo_out, 8'h22);

        // STOP after 4 data bits discards the byte
        i2c_start();
        write_byte(8'h54, ack); check("abort addr ack", ack, 1'b1);
        write_byte(8'h00, ack); check("abort ptr ack", ack, 1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        check("abort no write", uo_out, 8'h22);

        i2c_start();
        write_byte(8'h54, ack); check("post abort addr ack", ack, 1'b1);
        write_byte(8'h00, ack); check("post abort ptr ack", ack, 1'b1);
        write_byte(8'h5A, ack); check("post abort data ack", ack, 1'b1);
        i2c_stop();
        check("post abort uo_out", uo_out, 8'h5A);

        // Reset while driving a 0 read bit
        i2c_start();
        write_byte(8'h54, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'h55, ack); check("rst rd addr ack", ack, 1'b1);
        check("rd msb0 driven", uio_oe, 8'h02);
        rst_n = 1'b1;
        #20;
        check("mid rst release", uio_oe, 8'h00);
        check("mid rst uo_out", uo_out, 8'h00);
        rst_n = 1'b0;
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;

        i2c_start();
        write_byte(8'h54, ack); check("final addr ack", ack, 1'b1);
        write_byte(8'h00, ack);
        write_byte(8'h3C, ack); check("final data ack", ack, 1'b1);
        i2c_stop();
        check("final uo_out", uo_out, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
